vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL expose parameter H_DISPLAY, default 640; visible pixels per line.
REQ-002 SHALL expose parameter H_FRONT, default 16; horizontal front porch, in pixels.
REQ-003 SHALL expose parameter H_SYNC, default 96; hsync pulse width, in pixels.
REQ-004 SHALL expose parameter H_BACK, default 48; horizontal back porch, in pixels.
REQ-005 SHALL expose parameter V_DISPLAY, default 480; visible lines per frame.
REQ-006 SHALL expose parameter V_FRONT, default 10; vertical front porch, in lines.
REQ-007 SHALL expose parameter V_SYNC, default 2; vsync pulse width, in lines.
REQ-008 SHALL expose parameter V_BACK, default 33; vertical back porch, in lines.
REQ-009 SHALL expose parameter CLK_DIV, default 4; system clocks per pixel (100 MHz to 25 MHz), legal range 1..16.
REQ-010 SHALL have port clk, input, 1 bit; single system clock, rising edge.
REQ-011 SHALL have port rst_n, input, 1 bit; asynchronous active-low reset.
REQ-012 SHALL have port p_tick, output, 1 bit; pixel-enable strobe.
REQ-013 SHALL have port x, output, 10 bits; horizontal pixel counter.
REQ-014 SHALL have port y, output, 10 bits; vertical line counter.
REQ-015 SHALL have port video_on, output, 1 bit; high inside the visible area.
REQ-016 SHALL have port hsync, output, 1 bit; active-low horizontal sync.
REQ-017 SHALL have port vsync, output, 1 bit; active-low vertical sync.
REQ-018 SHALL have port frame_start, output, 1 bit; one-clock pulse at frame origin.

Function
REQ-019 SHALL define H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (default 800) and V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (default 525); both totals SHALL be at most 1024.
REQ-020 Divider: SHALL count 0..CLK_DIV-1 and wrap to 0; p_tick SHALL be high for exactly one clk when the divider equals CLK_DIV-1; with CLK_DIV=1, p_tick SHALL be constantly high.
REQ-021 x SHALL advance only on clks where p_tick=1, and SHALL wrap from H_TOTAL-1 to 0.
REQ-022 y SHALL advance only on the p_tick where x wraps, and SHALL wrap from V_TOTAL-1 to 0 on that same p_tick.
REQ-023 video_on SHALL be 1 iff x < H_DISPLAY and y < V_DISPLAY.
REQ-024 hsync SHALL be 0 iff H_DISPLAY+H_FRONT <= x <= H_DISPLAY+H_FRONT+H_SYNC-1 (default 656..751); otherwise 1.
REQ-025 vsync SHALL be 0 iff V_DISPLAY+V_FRONT <= y <= V_DISPLAY+V_FRONT+V_SYNC-1 (default 490..491); otherwise 1.
REQ-026 video_on, hsync and vsync SHALL be registered, computed from next-state counter values, so that in every clk cycle they correspond to the current x and y (zero relative skew, no combinational decode glitches).
REQ-027 frame_start SHALL be a one-clk pulse on the clk edge where x and y both transition to 0 via wrap; it SHALL NOT assert on reset release.
REQ-028 Outside p_tick cycles, x, y, video_on, hsync and vsync SHALL hold their values.
REQ-029 Downstream stages SHALL sample x, y and video_on on p_tick; x and y are guaranteed stable for CLK_DIV clks.

Reset
REQ-030 While rst_n=0, asynchronously: divider=0, x=0, y=0, p_tick=0, frame_start=0, hsync=1, vsync=1, video_on=1 (consistent with the origin).
REQ-031 Reset asserted mid-frame SHALL take effect immediately, without waiting for clk; after release, the first p_tick SHALL occur CLK_DIV clks later, and the first x increment on that p_tick.

Verification
REQ-032 Reset release with defaults -> p_tick pulses every 4 clks, each 1 clk wide; x steps 0,1,2,... once per p_tick.
REQ-033 Run one line -> x wraps 799 to 0 and y increments, after 3200 clks; hsync is low for exactly 96 p_ticks, from x=656 to x=751 inclusive.
REQ-034 Run one frame -> vsync is low exactly during y=490..491 (1600 p_ticks); y wraps 524 to 0; frame_start pulses once per 420000 p_ticks (1,680,000 clks).
REQ-035 Check the visible boundary -> video_on=1 at (639,479), 0 at (640,0), 0 at (0,480), 1 at (0,0); video_on, hsync and vsync change only on the clk where x or y changes.
REQ-036 Assert rst_n=0 at (x=700, y=300) between clk edges -> outputs take their reset values before the next clk edge; after release, counting resumes from (0,0) with no frame_start.
REQ-037 Parameter override CLK_DIV=1, H_DISPLAY=8, H_FRONT=1, H_SYNC=2, H_BACK=1, V_DISPLAY=4, V_FRONT=1, V_SYNC=1, V_BACK=1 -> p_tick constantly high, line period 12 clks, frame period 84 clks, hsync low at x=9..10.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator.
// A clock divider produces a one-clk pixel strobe (p_tick). Horizontal and
// vertical counters advance on that strobe. The sync, blanking and
// frame-origin outputs are registered from the counters' next-state values,
// so they always line up with the x/y values currently on the outputs.
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,  // visible pixels per line
    parameter int H_FRONT   = 16,   // horizontal front porch (pixels)
    parameter int H_SYNC    = 96,   // hsync pulse width (pixels)
    parameter int H_BACK    = 48,   // horizontal back porch (pixels)
    parameter int V_DISPLAY = 480,  // visible lines per frame
    parameter int V_FRONT   = 10,   // vertical front porch (lines)
    parameter int V_SYNC    = 2,    // vsync pulse width (lines)
    parameter int V_BACK    = 33,   // vertical back porch (lines)
    parameter int CLK_DIV   = 4     // system clocks per pixel, 1..16
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       p_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start
);

    // Both totals must fit the 10-bit counters (at most 1024).
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // Decode boundaries are kept 11 bits wide so a 1024-wide region
    // still compares correctly against a zero-extended 10-bit counter.
    localparam logic [10:0] H_VIS_END  = 11'(H_DISPLAY);
    localparam logic [10:0] V_VIS_END  = 11'(V_DISPLAY);
    localparam logic [10:0] HS_FIRST   = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] HS_LAST    = 11'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [10:0] VS_FIRST   = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] VS_LAST    = 11'(V_DISPLAY + V_FRONT + V_SYNC - 1);
    localparam logic [9:0]  X_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  Y_LAST     = 10'(V_TOTAL - 1);
    localparam logic [3:0]  DIV_LAST   = 4'(CLK_DIV - 1);

    logic [3:0] div_q,   div_d;
    logic       p_tick_q, p_tick_d;
    logic [9:0] x_q,     x_d;
    logic [9:0] y_q,     y_d;
    logic       video_on_q, video_on_d;
    logic       hsync_q,    hsync_d;
    logic       vsync_q,    vsync_d;
    logic       frame_start_q, frame_start_d;
    logic       x_wrap, y_wrap;

    // Divider: counts 0..CLK_DIV-1. The strobe is a registered decode of the
    // terminal count, so it is glitch-free, stays low through reset even for
    // CLK_DIV=1, and first rises exactly CLK_DIV clks after reset release.
    always_comb begin
        div_d    = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
        p_tick_d = (div_q == DIV_LAST);
    end

    // Raster counters: x steps on each strobe, y steps when x wraps.
    always_comb begin
        x_wrap = (x_q == X_LAST);
        y_wrap = (y_q == Y_LAST);
        x_d    = x_q;
        y_d    = y_q;
        if (p_tick_q) begin
            x_d = x_wrap ? 10'd0 : x_q + 10'd1;
            if (x_wrap) begin
                y_d = y_wrap ? 10'd0 : y_q + 10'd1;
            end
        end
    end

    // Output decode from next-state counters; registering it makes the flags
    // change on the same edge as x/y, with no decode glitches.
    always_comb begin
        video_on_d    = ({1'b0, x_d} < H_VIS_END) && ({1'b0, y_d} < V_VIS_END);
        hsync_d       = !(({1'b0, x_d} >= HS_FIRST) && ({1'b0, x_d} <= HS_LAST));
        vsync_d       = !(({1'b0, y_d} >= VS_FIRST) && ({1'b0, y_d} <= VS_LAST));
        frame_start_d = p_tick_q && x_wrap && y_wrap;
    end

    // State registers; reset puts the raster at its origin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q         <= 4'd0;
            p_tick_q      <= 1'b0;
            x_q           <= 10'd0;
            y_q           <= 10'd0;
            video_on_q    <= 1'b1;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            p_tick_q      <= p_tick_d;
            x_q           <= x_d;
            y_q           <= y_d;
            video_on_q    <= video_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign p_tick      = p_tick_q;
    assign x           = x_q;
    assign y           = y_q;
    assign video_on    = video_on_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;

endmodule
